// File: rtl/mat_pkg.sv
// Shared types and default sizing for the ping-pong matrix loader.
package mat_pkg;

   typedef enum logic {
      RD_IDLE,
      RD_DRAIN
   } rd_state_t;

   localparam int unsigned DEF_DW  = 64;
   localparam int unsigned DEF_DIM = 5;

endpackage

// File: rtl/tile_raster_ctr.sv
// Raster-order x/y tile counter: x runs fastest and wraps into y; (DIM-1,DIM-1) wraps to (0,0).
module tile_raster_ctr #(
   parameter  int unsigned DIM = 5,
   localparam int unsigned AW  = $clog2(DIM)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [AW-1:0] x,
   output logic [AW-1:0] y,
   output logic          last
);

   localparam logic [AW-1:0] MAX = AW'(DIM - 1);

   logic [AW-1:0] x_q, x_d;
   logic [AW-1:0] y_q, y_d;

   // clr applies to the current coordinate so the caller can use (0,0) in the same cycle
   assign x    = clr ? '0 : x_q;
   assign y    = clr ? '0 : y_q;
   assign last = (x == MAX) && (y == MAX);

   always_comb begin
      x_d = x;
      y_d = y;
      if (en) begin
         if (x == MAX) begin
            x_d = '0;
            y_d = (y == MAX) ? '0 : y + AW'(1);
         end else begin
            x_d = x + AW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule

// File: rtl/mat_pingpong_loader.sv
// Double-buffered DIMxDIM matrix loader: fills one memory bank from the upstream stream
// while the other, completed bank is drained downstream.
module mat_pingpong_loader
   import mat_pkg::*;
#(
   parameter  int unsigned DW  = DEF_DW,
   parameter  int unsigned DIM = DEF_DIM,
   localparam int unsigned AW  = $clog2(DIM)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pushin,
   input  logic          firstin,
   input  logic [DW-1:0] din,
   output logic          stopin,
   output logic          drop,
   output logic          mwr,
   output logic          mwbank,
   output logic [AW-1:0] mwx,
   output logic [AW-1:0] mwy,
   output logic [DW-1:0] mwd,
   output logic          mrbank,
   output logic [AW-1:0] mrx,
   output logic [AW-1:0] mry,
   output logic          pushout,
   output logic          firstout,
   input  logic          stopout
);

   logic [1:0]    full_q, full_d;
   logic          wbank_q, wbank_d;
   logic          rbank_q, rbank_d;
   logic          mwr_q, mwr_d;
   logic          mwbank_q, mwbank_d;
   logic [AW-1:0] mwx_q, mwx_d;
   logic [AW-1:0] mwy_q, mwy_d;
   logic [DW-1:0] mwd_q, mwd_d;
   logic          drop_q, drop_d;
   rd_state_t     state_q, state_d;
   logic          pushout_q, pushout_d;
   logic          firstout_q, firstout_d;

   logic          accept, xfer, rd_clr, rd_en;
   logic [AW-1:0] wx, wy, rx, ry;
   logic          w_last, r_last;

   // The writer only stalls when the bank it is parked on still holds an undrained matrix
   assign stopin = full_q[wbank_q];
   assign accept = pushin & ~stopin;
   assign xfer   = pushout_q & ~stopout;
   assign rd_clr = (state_q == RD_IDLE) & full_q[rbank_q];
   assign rd_en  = (state_q == RD_DRAIN) & xfer & ~r_last;

   tile_raster_ctr #(.DIM(DIM)) u_wr_ptr (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept & firstin),
      .en   (accept),
      .x    (wx),
      .y    (wy),
      .last (w_last)
   );

   tile_raster_ctr #(.DIM(DIM)) u_rd_ptr (
      .clk  (clk),
      .rst  (rst),
      .clr  (rd_clr),
      .en   (rd_en),
      .x    (rx),
      .y    (ry),
      .last (r_last)
   );

   always_comb begin
      full_d     = full_q;
      wbank_d    = wbank_q;
      rbank_d    = rbank_q;
      state_d    = state_q;
      pushout_d  = pushout_q;
      firstout_d = firstout_q;
      mwr_d      = accept;
      mwbank_d   = accept ? wbank_q : mwbank_q;
      mwx_d      = accept ? wx : mwx_q;
      mwy_d      = accept ? wy : mwy_q;
      mwd_d      = accept ? din : mwd_q;
      drop_d     = pushin & stopin;

      if (accept && w_last) begin
         full_d[wbank_q] = 1'b1;
         wbank_d         = ~wbank_q;
      end

      // Writer and reader never target the same bank here, so both full updates can land together
      unique case (state_q)
         RD_IDLE: begin
            if (full_q[rbank_q]) begin
               state_d    = RD_DRAIN;
               pushout_d  = 1'b1;
               firstout_d = 1'b1;
            end
         end
         RD_DRAIN: begin
            if (xfer) begin
               firstout_d = 1'b0;
               if (r_last) begin
                  pushout_d       = 1'b0;
                  full_d[rbank_q] = 1'b0;
                  rbank_d         = ~rbank_q;
                  state_d         = RD_IDLE;
               end
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q     <= '0;
         wbank_q    <= 1'b0;
         rbank_q    <= 1'b0;
         mwr_q      <= 1'b0;
         mwbank_q   <= 1'b0;
         mwx_q      <= '0;
         mwy_q      <= '0;
         mwd_q      <= '0;
         drop_q     <= 1'b0;
         state_q    <= RD_IDLE;
         pushout_q  <= 1'b0;
         firstout_q <= 1'b0;
      end else begin
         full_q     <= full_d;
         wbank_q    <= wbank_d;
         rbank_q    <= rbank_d;
         mwr_q      <= mwr_d;
         mwbank_q   <= mwbank_d;
         mwx_q      <= mwx_d;
         mwy_q      <= mwy_d;
         mwd_q      <= mwd_d;
         drop_q     <= drop_d;
         state_q    <= state_d;
         pushout_q  <= pushout_d;
         firstout_q <= firstout_d;
      end
   end

   assign drop     = drop_q;
   assign mwr      = mwr_q;
   assign mwbank   = mwbank_q;
   assign mwx      = mwx_q;
   assign mwy      = mwy_q;
   assign mwd      = mwd_q;
   assign mrbank   = rbank_q;
   assign mrx      = rx;
   assign mry      = ry;
   assign pushout  = pushout_q;
   assign firstout = firstout_q;

endmodule

// File: tb/tb_mat_pingpong_loader.sv
// Randomised scoreboard bench for mat_pingpong_loader with a behavioural 2-bank matrix memory.
module tb_mat_pingpong_loader;

   localparam int unsigned DW  = 64;
   localparam int unsigned DIM = 5;
   localparam int unsigned AW  = $clog2(DIM);
   localparam int          NEL = DIM * DIM;

   logic          clk = 1'b0;
   logic          rst;
   logic          pushin, firstin, stopout;
   logic [DW-1:0] din;
   logic          stopin, drop, mwr, mwbank, mrbank, pushout, firstout;
   logic [AW-1:0] mwx, mwy, mrx, mry;
   logic [DW-1:0] mwd;

   mat_pingpong_loader #(.DW(DW), .DIM(DIM)) dut (
      .clk      (clk),
      .rst      (rst),
      .pushin   (pushin),
      .firstin  (firstin),
      .din      (din),
      .stopin   (stopin),
      .drop     (drop),
      .mwr      (mwr),
      .mwbank   (mwbank),
      .mwx      (mwx),
      .mwy      (mwy),
      .mwd      (mwd),
      .mrbank   (mrbank),
      .mrx      (mrx),
      .mry      (mry),
      .pushout  (pushout),
      .firstout (firstout),
      .stopout  (stopout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural matrix memory, combinational read
   logic [DW-1:0] mem [2][DIM][DIM];
   always @(posedge clk) if (mwr) mem[mwbank][mwy][mwx] <= mwd;

   typedef struct {
      int            cyc;
      logic          bank;
      int            x;
      int            y;
      logic [DW-1:0] d;
   } wr_t;

   typedef struct {
      logic [DW-1:0] d;
      logic          bank;
      int            idx;
      int            ready;
   } rd_t;

   wr_t wq[$];
   int  dq[$];
   rd_t rq[$];

   // Reference model: current fill bank/index, partial matrix, count of undrained matrices
   logic          m_bank;
   int            m_idx;
   logic [DW-1:0] m_buf [NEL];
   int            pending;
   int            last_xfer;
   logic          prev_po;
   logic          bubble;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd();
      return {$urandom(), $urandom()};
   endfunction

   task automatic model_clear();
      wq.delete();
      dq.delete();
      rq.delete();
      m_bank  = 1'b0;
      m_idx   = 0;
      pending = 0;
   endtask

   // One cycle of stimulus; expectations are queued for the monitor
   task automatic drive(input logic p, input logic f, input logic [DW-1:0] d, input logic so);
      wr_t w;
      rd_t r;
      @(posedge clk);
      #2;
      chk("stopin", stopin, 64'(pending == 2));
      pushin  = p;
      firstin = f;
      din     = d;
      stopout = so;
      if (p) begin
         if (pending == 2) begin
            dq.push_back(cyc);
         end else begin
            if (f) m_idx = 0;
            w.cyc  = cyc;
            w.bank = m_bank;
            w.x    = m_idx % DIM;
            w.y    = m_idx / DIM;
            w.d    = d;
            wq.push_back(w);
            m_buf[m_idx] = d;
            m_idx++;
            if (m_idx == NEL) begin
               for (int i = 0; i < NEL; i++) begin
                  r.d     = m_buf[i];
                  r.bank  = m_bank;
                  r.idx   = i;
                  r.ready = cyc + 2;
                  rq.push_back(r);
               end
               pending++;
               m_bank = ~m_bank;
               m_idx  = 0;
            end
         end
      end
   endtask

   task automatic idle(input int n, input logic so);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, so);
   endtask

   task automatic rand_cycles(input int n, input int push_pct, input int first_pct,
                              input int stop_pct);
      for (int i = 0; i < n; i++)
         drive(64'($urandom_range(99)) < 64'(push_pct), 64'($urandom_range(99)) < 64'(first_pct),
               rnd(), 64'($urandom_range(99)) < 64'(stop_pct));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("rst_stopin", stopin, 0);
      chk("rst_drop", drop, 0);
      chk("rst_mwr", mwr, 0);
      chk("rst_mwbank", mwbank, 0);
      chk("rst_mwx", mwx, 0);
      chk("rst_mwy", mwy, 0);
      chk("rst_mwd", mwd, 0);
      chk("rst_mrbank", mrbank, 0);
      chk("rst_mrx", mrx, 0);
      chk("rst_mry", mry, 0);
      chk("rst_pushout", pushout, 0);
      chk("rst_firstout", firstout, 0);
      model_clear();
      pushin  = 1'b0;
      firstin = 1'b0;
      stopout = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   // Monitor: samples on the falling edge and pops expectations as the DUT presents them
   initial begin
      wr_t  w;
      rd_t  r;
      logic exp_wr, exp_drop;
      prev_po   = 1'b0;
      bubble    = 1'b0;
      last_xfer = -100;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_po   = 1'b0;
            bubble    = 1'b0;
            last_xfer = -100;
            continue;
         end
         exp_wr = (wq.size() > 0) && (wq[0].cyc == cyc - 1);
         chk("mwr", mwr, 64'(exp_wr));
         if (exp_wr) begin
            w = wq.pop_front();
            chk("mwbank", mwbank, 64'(w.bank));
            chk("mwx", mwx, 64'(w.x));
            chk("mwy", mwy, 64'(w.y));
            chk("mwd", mwd, w.d);
         end
         exp_drop = (dq.size() > 0) && (dq[0] == cyc - 1);
         chk("drop", drop, 64'(exp_drop));
         if (exp_drop) void'(dq.pop_front());
         if (bubble) chk("bubble", pushout, 0);
         bubble = 1'b0;
         if (pushout) begin
            if (rq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pushout at cycle %0d: got 1 expected 0", cyc);
            end else begin
               r = rq[0];
               if (!prev_po)
                  chk("start_cycle", 64'(cyc),
                      64'((r.ready > last_xfer + 2) ? r.ready : last_xfer + 2));
               chk("firstout", firstout, 64'(r.idx == 0));
               chk("mrbank", mrbank, 64'(r.bank));
               chk("mrx", mrx, 64'(r.idx % DIM));
               chk("mry", mry, 64'(r.idx / DIM));
               chk("rdata", mem[mrbank][mry][mrx], r.d);
               if (!stopout) begin
                  void'(rq.pop_front());
                  if (r.idx == NEL - 1) begin
                     pending--;
                     last_xfer = cyc;
                     bubble    = 1'b1;
                  end
               end
            end
         end
         prev_po = pushout;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst     = 1'b1;
      pushin  = 1'b0;
      firstin = 1'b0;
      din     = '0;
      stopout = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;

      // Mid-stream reset, then first push without firstin lands at (0,0) bank 0
      rand_cycles(40, 80, 5, 20);
      drive(1'b1, 1'b0, rnd(), 1'b0);
      do_reset();
      idle(2, 1'b0);

      // Single matrix 0..24
      for (int i = 0; i < NEL; i++) drive(1'b1, i == 0, DW'(i), 1'b0);
      idle(32, 1'b0);

      // Fill both banks under downstream stall, then one rejected push
      for (int i = 0; i < 2 * NEL; i++) drive(1'b1, 1'b0, rnd(), 1'b1);
      drive(1'b1, 1'b0, rnd(), 1'b1);
      idle(3, 1'b1);
      idle(20, 1'b0);
      rand_cycles(10, 50, 0, 0);
      idle(40, 1'b0);

      // firstin restart on the 8th word
      for (int i = 0; i < 7 + NEL; i++) drive(1'b1, (i == 0) || (i == 7), rnd(), 1'b0);
      idle(35, 1'b0);

      // Downstream stall toggling every cycle during a drain
      for (int i = 0; i < NEL; i++) drive(1'b1, i == 0, rnd(), 1'b0);
      for (int i = 0; i < 70; i++) drive(1'b0, 1'b0, '0, i[0]);

      // Continuous three-matrix stream
      for (int i = 0; i < 3 * NEL; i++) drive(1'b1, i == 0, rnd(), 1'b0);
      idle(90, 1'b0);

      // Random traffic with restarts and stalls
      rand_cycles(600, 70, 3, 30);

      for (int i = 0; i < 400 && (rq.size() != 0 || wq.size() != 0 || dq.size() != 0); i++)
         idle(1, 1'b0);
      idle(3, 1'b0);
      chk("rd_queue_empty", 64'(rq.size()), 0);
      chk("wr_queue_empty", 64'(wq.size()), 0);
      chk("drop_queue_empty", 64'(dq.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
